// File: rtl/bus16_arbiter_pkg.sv
// Shared types and constants for the two-requester 16-bit burst arbiter.
package bus16_arbiter_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  // Beat held in the output register.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              src;
    logic              last;
  } beat_t;

endpackage

// File: rtl/bus16_arbiter_mux16.sv
// 16-bit 2:1 data select between requester A (sel=0) and requester B (sel=1).
module bus16_arbiter_mux16
  import bus16_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sel,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = a;
    if (sel) y = b;
  end

endmodule

// File: rtl/bus16_arbiter.sv
// Two-requester burst arbiter with alternating priority, per-grant beat limit
// and a single registered output stage.
module bus16_arbiter
  import bus16_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  output logic              b_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  output logic              out_last,
  input  logic              out_ready
);

  state_t            state, state_nxt;
  logic              prio, prio_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [CNT_W-1:0]  count_inc;
  logic              grant_src;
  logic              beat_last;
  logic              can_load;
  logic              load;
  logic              release_beat;
  logic [DATA_W-1:0] mux_data;
  logic              out_valid_q;
  beat_t             out_q;

  assign can_load  = !out_valid_q || out_ready;
  assign count_inc = count + CNT_W'(1);

  bus16_arbiter_mux16 u_mux (
    .a   (a_data),
    .b   (b_data),
    .sel (grant_src),
    .y   (mux_data)
  );

  // Next-state, handshake and release decision.
  always_comb begin
    state_nxt    = state;
    prio_nxt     = prio;
    count_nxt    = count;
    a_ready      = 1'b0;
    b_ready      = 1'b0;
    grant_src    = SRC_A;
    beat_last    = 1'b0;
    load         = 1'b0;
    release_beat = 1'b0;

    case (state)
      IDLE: begin
        count_nxt = '0;
        if (a_valid && (prio == SRC_A || !b_valid)) state_nxt = GRANT_A;
        else if (b_valid)                           state_nxt = GRANT_B;
      end
      GRANT_A: begin
        grant_src = SRC_A;
        a_ready   = can_load;
        beat_last = a_last;
        load      = a_valid && can_load;
      end
      GRANT_B: begin
        grant_src = SRC_B;
        b_ready   = can_load;
        beat_last = b_last;
        load      = b_valid && can_load;
      end
      default: state_nxt = IDLE;
    endcase

    release_beat = load && (beat_last || count_inc == CNT_W'(MAX_BURST));

    if (load) count_nxt = count_inc;

    // Closing beat hands priority to the other side and forces an idle bubble.
    if (release_beat) begin
      state_nxt = IDLE;
      prio_nxt  = ~grant_src;
      count_nxt = '0;
    end
  end

  // State, priority, counter and output register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      prio        <= SRC_A;
      count       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
      count <= count_nxt;
      if (load) begin
        out_valid_q <= 1'b1;
        out_q       <= '{data: mux_data, src: grant_src, last: release_beat};
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_q.data;
  assign out_src   = out_q.src;
  assign out_last  = out_q.last;

endmodule

// File: doc/bus16_arbiter.md
BUS16_ARBITER -- requirements
Module: bus16_arbiter

Interface
REQ-001 SHALL have parameter: MAX_BURST, 8, maximum beats per grant before forced release (legal range 1..15).
REQ-002 SHALL have port: clock input 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset_n input 1, reset that is synchronous and active-low.
REQ-004 SHALL have port: a_valid input 1, requester A beat valid.
REQ-005 SHALL have port: a_data input 16, requester A beat data.
REQ-006 SHALL have port: a_last input 1, requester A final beat of burst.
REQ-007 SHALL have port: a_ready output 1, requester A beat accepted this cycle when high with a_valid.
REQ-008 SHALL have ports b_valid, b_data, b_last and b_ready, with the same directions, widths and meanings as the A ports, for requester B.
REQ-009 SHALL have port: out_valid output 1, output register holds a beat.
REQ-010 SHALL have port: out_data output 16, registered beat data.
REQ-011 SHALL have port: out_src output 1, source of the held beat (0=A, 1=B).
REQ-012 SHALL have port: out_last output 1, held beat closes its grant (last flag or forced release).
REQ-013 SHALL have port: out_ready input 1, downstream consumes the held beat when high with out_valid.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT_A and GRANT_B.
REQ-015 In IDLE, the FSM SHALL go to GRANT_A if a_valid and (prio==A or !b_valid), otherwise to GRANT_B if b_valid, otherwise stay in IDLE.
REQ-016 The ready output of the granted requester SHALL equal (!out_valid || out_ready); the other ready output and both readies in IDLE SHALL be 0.
REQ-017 A beat SHALL transfer when x_valid && x_ready, and SHALL be loaded into the output register at the next edge with out_src = granted source.
REQ-018 The data select SHALL use the grant (0=A, 1=B) as the select of the 16-bit mux.
REQ-019 The output register SHALL clear out_valid when out_ready is high and no new beat is loaded in that cycle.
REQ-020 Simultaneous consume and load SHALL replace the held beat, giving throughput of 1 beat/cycle.
REQ-021 The beat counter (4 bits) SHALL clear on grant entry and increment per transferred beat.
REQ-022 Release SHALL occur on a transferred beat with x_last=1, or when that beat brings count to MAX_BURST; out_last SHALL be 1 for that beat.
REQ-023 On release, the FSM SHALL return to IDLE and prio SHALL be set to the other requester, giving one idle bubble cycle between grants.
REQ-024 While granted, deassertion of x_valid SHALL NOT release the grant; the FSM SHALL hold the grant and counter.
REQ-025 Simultaneous a_valid and b_valid in IDLE SHALL be resolved by prio only.
REQ-026 A lone requester SHALL be granted regardless of prio.
REQ-027 Backpressure (out_ready=0 with out_valid=1) SHALL stall the transfer without data loss or duplication.

Reset
REQ-028 reset_n=0 sampled at a clock edge SHALL force: state IDLE, prio A, count 0, out_valid 0, out_data 0, out_src 0, out_last 0.
REQ-029 a_ready and b_ready SHALL be 0 during and after reset until a grant is taken.
REQ-030 Reset asserted mid-burst SHALL abort the burst and discard the held beat; no beat SHALL be emitted in the first cycle after reset deassertion.

Structure
REQ-031 A shared package SHALL hold the state encodings (IDLE=2'd0, GRANT_A=2'd1, GRANT_B=2'd2), source IDs (SRC_A=0, SRC_B=1) and the counter width constant (4).
REQ-032 The block SHALL instantiate one Mux16 for the a_data/b_data selection; all other logic SHALL be local to the block.

Verification
REQ-033 Reset then idle: reset_n=0 for 2 cycles, no valids -> out_valid=0, a_ready=b_ready=0, state IDLE.
REQ-034 Contention: a_valid=b_valid=1 from IDLE, single-beat bursts with last=1 and out_ready=1 -> out_src sequence 0,1,0,1; data matches 16'hA000+n and 16'hB000+n; one bubble between grants.
REQ-035 Forced release: MAX_BURST=4, A streams 10 beats with last=0 -> out_last=1 on beat 4, then B is granted if b_valid=1, then A resumes with beat 5.
REQ-036 Backpressure: out_ready held 0 for 3 cycles mid-burst of 16'h1234,16'h5678 -> out_data stays 16'h1234 and a_ready=0; after out_ready=1 -> both beats emitted in order, none duplicated.
REQ-037 Reset mid-burst: reset_n=0 during beat 2 of a B burst -> out_valid=0 next cycle, prio=A; a subsequent simultaneous request grants A first.
